// File: rtl/pe_array_id_pkg.sv
// Shared PE ID-stage definitions: instruction field layout, opcode values,
// bypass/predication encodings and the bypass-only register threshold.
package pe_array_id_pkg;

  localparam int OPC_WIDTH = 7;
  localparam int OPC_LSB   = 17;
  localparam int DEST_LSB  = 12;
  localparam int IMM_LSB   = 0;
  localparam int IMM_WIDTH = 12;

  localparam logic [OPC_WIDTH-1:0] OPC_NOP = 7'h00;
  localparam logic [OPC_WIDTH-1:0] OPC_ADD = 7'h01;
  localparam logic [OPC_WIDTH-1:0] OPC_SUB = 7'h02;
  localparam logic [OPC_WIDTH-1:0] OPC_LW  = 7'h10;
  localparam logic [OPC_WIDTH-1:0] OPC_SW  = 7'h11;

  // Register indices at or above this value are bypass aliases, never written.
  localparam int BYPASS_THRESHOLD = 28;

  typedef enum logic [1:0] {
    BP_EX    = 2'b00,
    BP_WB    = 2'b01,
    BP_LEFT  = 2'b10,
    BP_RIGHT = 2'b11
  } bp_sel_e;

  typedef enum logic [1:0] {
    PRED_ALWAYS = 2'b00,
    PRED_IF_SET = 2'b01,
    PRED_IF_CLR = 2'b10,
    PRED_NEVER  = 2'b11
  } pred_e;

  function automatic logic pred_exec(input logic [1:0] pred, input logic flag);
    logic r;
    case (pred_e'(pred))
      PRED_ALWAYS: r = 1'b1;
      PRED_IF_SET: r = flag;
      PRED_IF_CLR: r = ~flag;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pe_array_id_operand_sel.sv
// Combinational operand source select: RF read data or one of four bypass sources.
module pe_operand_sel
  import pe_array_id_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  bypass_read_i,
  input  logic [1:0]            bypass_sel_i,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  input  logic [DATA_WIDTH-1:0] ex_result_i,
  input  logic [DATA_WIDTH-1:0] wb_result_i,
  input  logic [DATA_WIDTH-1:0] left_data_i,
  input  logic [DATA_WIDTH-1:0] right_data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] bypass_data;

  always_comb begin
    bypass_data = ex_result_i;
    case (bp_sel_e'(bypass_sel_i))
      BP_EX:    bypass_data = ex_result_i;
      BP_WB:    bypass_data = wb_result_i;
      BP_LEFT:  bypass_data = left_data_i;
      BP_RIGHT: bypass_data = right_data_i;
      default:  bypass_data = ex_result_i;
    endcase
  end

  assign data_o = bypass_read_i ? bypass_data : rf_data_i;

endmodule

// File: rtl/pe_array_id.sv
// PE array instruction-decode stage: operand select, decode, predication,
// and the ID/EX pipeline register with reset/flush/stall control.
module pe_array_id
  import pe_array_id_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int INS_WIDTH      = 24,
  parameter int RF_INDEX_WIDTH = 5
) (
  input  logic                      iClk,
  input  logic                      iReset,
  input  logic                      iStall,
  input  logic                      iFlush,
  input  logic [INS_WIDTH-1:0]      iIF_ID_Instruction,
  input  logic [1:0]                iPredication,
  input  logic                      iIF_BP_Select_Imm,
  input  logic                      iIF_BP_Bypass_Read_A,
  input  logic                      iIF_BP_Bypass_Read_B,
  input  logic [1:0]                iIF_BP_Bypass_Sel_A,
  input  logic [1:0]                iIF_BP_Bypass_Sel_B,
  input  logic [2:0]                iIF_BP_Data_Selection,
  input  logic [DATA_WIDTH-1:0]     iRF_Read_Data_A,
  input  logic [DATA_WIDTH-1:0]     iRF_Read_Data_B,
  input  logic [DATA_WIDTH-1:0]     iBP_EX_Result,
  input  logic [DATA_WIDTH-1:0]     iBP_WB_Result,
  input  logic [DATA_WIDTH-1:0]     iBP_Left_Data,
  input  logic [DATA_WIDTH-1:0]     iBP_Right_Data,
  input  logic                      iPE_Flag,
  output logic [DATA_WIDTH-1:0]     oID_EX_Operand_A,
  output logic [DATA_WIDTH-1:0]     oID_EX_Operand_B,
  output logic [DATA_WIDTH-1:0]     oID_EX_Store_Data,
  output logic [OPC_WIDTH-1:0]      oID_EX_Opcode,
  output logic [RF_INDEX_WIDTH-1:0] oID_EX_Dest_Index,
  output logic                      oID_EX_Write_Enable,
  output logic                      oID_EX_Mem_Read,
  output logic                      oID_EX_Mem_Write,
  output logic [2:0]                oID_EX_Data_Selection,
  output logic                      oID_EX_Valid
);

  logic [DATA_WIDTH-1:0]     port_a_data, port_b_data;
  logic [OPC_WIDTH-1:0]      opcode;
  logic [RF_INDEX_WIDTH-1:0] dest;
  logic [IMM_WIDTH-1:0]      imm;
  logic [DATA_WIDTH-1:0]     imm_ext;
  logic                      exec;

  pe_operand_sel #(.DATA_WIDTH(DATA_WIDTH)) u_sel_a (
    .bypass_read_i (iIF_BP_Bypass_Read_A),
    .bypass_sel_i  (iIF_BP_Bypass_Sel_A),
    .rf_data_i     (iRF_Read_Data_A),
    .ex_result_i   (iBP_EX_Result),
    .wb_result_i   (iBP_WB_Result),
    .left_data_i   (iBP_Left_Data),
    .right_data_i  (iBP_Right_Data),
    .data_o        (port_a_data)
  );

  pe_operand_sel #(.DATA_WIDTH(DATA_WIDTH)) u_sel_b (
    .bypass_read_i (iIF_BP_Bypass_Read_B),
    .bypass_sel_i  (iIF_BP_Bypass_Sel_B),
    .rf_data_i     (iRF_Read_Data_B),
    .ex_result_i   (iBP_EX_Result),
    .wb_result_i   (iBP_WB_Result),
    .left_data_i   (iBP_Left_Data),
    .right_data_i  (iBP_Right_Data),
    .data_o        (port_b_data)
  );

  assign opcode  = iIF_ID_Instruction[OPC_LSB +: OPC_WIDTH];
  assign dest    = iIF_ID_Instruction[DEST_LSB +: RF_INDEX_WIDTH];
  assign imm     = iIF_ID_Instruction[IMM_LSB +: IMM_WIDTH];
  assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign exec    = pred_exec(iPredication, iPE_Flag);

  logic [DATA_WIDTH-1:0]     operand_a_q, operand_a_d;
  logic [DATA_WIDTH-1:0]     operand_b_q, operand_b_d;
  logic [DATA_WIDTH-1:0]     store_data_q, store_data_d;
  logic [OPC_WIDTH-1:0]      opcode_q, opcode_d;
  logic [RF_INDEX_WIDTH-1:0] dest_q, dest_d;
  logic                      write_enable_q, write_enable_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [2:0]                data_sel_q, data_sel_d;
  logic                      valid_q, valid_d;

  // Squashed instructions still carry operands/opcode/dest; only side effects drop.
  always_comb begin
    operand_a_d    = port_a_data;
    operand_b_d    = iIF_BP_Select_Imm ? imm_ext : port_b_data;
    store_data_d   = port_b_data;
    opcode_d       = opcode;
    dest_d         = dest;
    data_sel_d     = iIF_BP_Data_Selection;
    valid_d        = exec;
    mem_read_d     = exec && (opcode == OPC_LW);
    mem_write_d    = exec && (opcode == OPC_SW);
    write_enable_d = exec && (opcode != OPC_SW) && (opcode != OPC_NOP)
                     && (dest < RF_INDEX_WIDTH'(BYPASS_THRESHOLD));
  end

  always_ff @(posedge iClk) begin
    if (iReset || iFlush) begin
      operand_a_q    <= '0;
      operand_b_q    <= '0;
      store_data_q   <= '0;
      opcode_q       <= OPC_NOP;
      dest_q         <= '0;
      write_enable_q <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      data_sel_q     <= '0;
      valid_q        <= 1'b0;
    end else if (!iStall) begin
      operand_a_q    <= operand_a_d;
      operand_b_q    <= operand_b_d;
      store_data_q   <= store_data_d;
      opcode_q       <= opcode_d;
      dest_q         <= dest_d;
      write_enable_q <= write_enable_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      data_sel_q     <= data_sel_d;
      valid_q        <= valid_d;
    end
  end

  assign oID_EX_Operand_A      = operand_a_q;
  assign oID_EX_Operand_B      = operand_b_q;
  assign oID_EX_Store_Data     = store_data_q;
  assign oID_EX_Opcode         = opcode_q;
  assign oID_EX_Dest_Index     = dest_q;
  assign oID_EX_Write_Enable   = write_enable_q;
  assign oID_EX_Mem_Read       = mem_read_q;
  assign oID_EX_Mem_Write      = mem_write_q;
  assign oID_EX_Data_Selection = data_sel_q;
  assign oID_EX_Valid          = valid_q;

endmodule

// File: tb/tb_pe_array_id.sv
// Directed plus randomized checks of the PE ID stage against a field-level model.
module tb_pe_array_id;
  import pe_array_id_pkg::*;

  localparam int DW = 32;
  localparam int IW = 24;
  localparam int RW = 5;
  localparam int OW = OPC_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, stall, flush;
  logic [IW-1:0] ins;
  logic [1:0]    pred;
  logic          sel_imm, byp_a, byp_b;
  logic [1:0]    sel_a, sel_b;
  logic [2:0]    dsel;
  logic [DW-1:0] rf_a, rf_b, ex_r, wb_r, left_d, right_d;
  logic          flag;

  logic [DW-1:0] o_a, o_b, o_sd;
  logic [OW-1:0] o_opc;
  logic [RW-1:0] o_dest;
  logic          o_we, o_mr, o_mw, o_valid;
  logic [2:0]    o_dsel;

  pe_array_id #(.DATA_WIDTH(DW), .INS_WIDTH(IW), .RF_INDEX_WIDTH(RW)) dut (
    .iClk                  (clk),
    .iReset                (rst),
    .iStall                (stall),
    .iFlush                (flush),
    .iIF_ID_Instruction    (ins),
    .iPredication          (pred),
    .iIF_BP_Select_Imm     (sel_imm),
    .iIF_BP_Bypass_Read_A  (byp_a),
    .iIF_BP_Bypass_Read_B  (byp_b),
    .iIF_BP_Bypass_Sel_A   (sel_a),
    .iIF_BP_Bypass_Sel_B   (sel_b),
    .iIF_BP_Data_Selection (dsel),
    .iRF_Read_Data_A       (rf_a),
    .iRF_Read_Data_B       (rf_b),
    .iBP_EX_Result         (ex_r),
    .iBP_WB_Result         (wb_r),
    .iBP_Left_Data         (left_d),
    .iBP_Right_Data        (right_d),
    .iPE_Flag              (flag),
    .oID_EX_Operand_A      (o_a),
    .oID_EX_Operand_B      (o_b),
    .oID_EX_Store_Data     (o_sd),
    .oID_EX_Opcode         (o_opc),
    .oID_EX_Dest_Index     (o_dest),
    .oID_EX_Write_Enable   (o_we),
    .oID_EX_Mem_Read       (o_mr),
    .oID_EX_Mem_Write      (o_mw),
    .oID_EX_Data_Selection (o_dsel),
    .oID_EX_Valid          (o_valid)
  );

  typedef struct packed {
    logic [DW-1:0] a, b, sd;
    logic [OW-1:0] opc;
    logic [RW-1:0] dest;
    logic          we, mr, mw;
    logic [2:0]    dsel;
    logic          valid;
  } exp_t;

  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [IW-1:0] mk_ins(input logic [OW-1:0] opc, input int dest, input int imm);
    return IW'((int'(opc) * (1 << 17)) + ((dest % 32) * 4096) + (imm % 4096));
  endfunction

  // Expected ID/EX contents derived from the instruction fields with plain arithmetic.
  function automatic exp_t predict();
    exp_t          r;
    logic [DW-1:0] src [4];
    logic [DW-1:0] pa, pb;
    int            opc, dest, imm;
    bit            ex_ok;
    src[0] = ex_r; src[1] = wb_r; src[2] = left_d; src[3] = right_d;
    pa   = byp_a ? src[sel_a] : rf_a;
    pb   = byp_b ? src[sel_b] : rf_b;
    opc  = int'(ins) / (1 << 17);
    dest = (int'(ins) / 4096) % 32;
    imm  = int'(ins) % 4096;
    if (imm >= 2048) imm = imm - 4096;
    case (pred)
      2'd0:    ex_ok = 1'b1;
      2'd1:    ex_ok = flag;
      2'd2:    ex_ok = !flag;
      default: ex_ok = 1'b0;
    endcase
    r       = '0;
    r.a     = pa;
    r.b     = sel_imm ? DW'(imm) : pb;
    r.sd    = pb;
    r.opc   = OW'(opc);
    r.dest  = RW'(dest);
    r.dsel  = dsel;
    r.valid = ex_ok;
    r.mr    = ex_ok && (opc == int'(OPC_LW));
    r.mw    = ex_ok && (opc == int'(OPC_SW));
    r.we    = ex_ok && (opc != int'(OPC_SW)) && (opc != int'(OPC_NOP)) && (dest < 28);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".opA"},   o_a,     e.a);
    chk({tag, ".opB"},   o_b,     e.b);
    chk({tag, ".sd"},    o_sd,    e.sd);
    chk({tag, ".opc"},   DW'(o_opc),  DW'(e.opc));
    chk({tag, ".dest"},  DW'(o_dest), DW'(e.dest));
    chk({tag, ".we"},    DW'(o_we),   DW'(e.we));
    chk({tag, ".mr"},    DW'(o_mr),   DW'(e.mr));
    chk({tag, ".mw"},    DW'(o_mw),   DW'(e.mw));
    chk({tag, ".dsel"},  DW'(o_dsel), DW'(e.dsel));
    chk({tag, ".valid"}, DW'(o_valid), DW'(e.valid));
    $display("%s: ins=%h pred=%0d rst=%0b stall=%0b flush=%0b -> opA=%h opB=%h opc=%h v=%0b we=%0b",
             tag, ins, pred, rst, stall, flush, o_a, o_b, o_opc, o_valid, o_we);
  endtask

  task automatic step(input string tag);
    if (rst || flush) begin
      e     = '0;
      e.opc = OPC_NOP;
    end else if (!stall) begin
      e = predict();
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_inputs();
    logic [OW-1:0] opcs [5];
    opcs[0] = OPC_NOP; opcs[1] = OPC_ADD; opcs[2] = OPC_LW; opcs[3] = OPC_SW;
    opcs[4] = OW'($urandom);
    ins     = mk_ins(opcs[$urandom_range(0, 4)], int'($urandom_range(0, 31)), int'($urandom_range(0, 4095)));
    pred    = 2'($urandom);
    sel_imm = 1'($urandom);
    byp_a   = 1'($urandom);
    byp_b   = 1'($urandom);
    sel_a   = 2'($urandom);
    sel_b   = 2'($urandom);
    dsel    = 3'($urandom);
    rf_a    = $urandom; rf_b = $urandom;
    ex_r    = $urandom; wb_r = $urandom;
    left_d  = $urandom; right_d = $urandom;
    flag    = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    step("reset0");
    rand_inputs();
    ins = mk_ins(OPC_LW, 7, 100); pred = 2'd0;
    step("reset_nonzero");
    rst = 1'b0;

    // Bypass source select on both ports
    for (int s = 0; s < 4; s++) begin
      rand_inputs();
      ins = mk_ins(OPC_ADD, 3, 5); pred = 2'd0; sel_imm = 1'b0;
      rf_a = 32'hFFFF_FFFF; rf_b = 32'hEEEE_EEEE;
      left_d = 32'h1234_5678;
      byp_a = 1'b1; byp_b = 1'b1; sel_a = 2'(s); sel_b = 2'(s);
      step($sformatf("bypass_sel%0d", s));
      if (s == 2) chk("bypass_left_const", o_a, 32'h1234_5678);
    end

    // Sign-extended immediate
    rand_inputs();
    ins = mk_ins(OPC_ADD, 4, 12'hF80); sel_imm = 1'b1; pred = 2'd0;
    step("imm_neg");
    chk("imm_const", o_b, 32'hFFFF_FF80);

    // Predication
    rand_inputs();
    ins = mk_ins(OPC_LW, 6, 8); pred = 2'b01; flag = 1'b0;
    step("pred01_f0");
    chk("pred01_valid", DW'(o_valid), 32'd0);
    pred = 2'b10; flag = 1'b0;
    step("pred10_f0");
    chk("pred10_mr", DW'(o_mr), 32'd1);
    pred = 2'b11; flag = 1'b1;
    step("pred11");

    // Destination guard
    ins = mk_ins(OPC_ADD, 29, 1); pred = 2'b00;
    step("dest29");
    chk("dest29_we", DW'(o_we), 32'd0);
    ins = mk_ins(OPC_ADD, 5, 1);
    step("dest5");
    chk("dest5_we", DW'(o_we), 32'd1);

    // Stall for three cycles while inputs change
    rand_inputs(); pred = 2'b00;
    step("pre_stall");
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      step($sformatf("stall%0d", k));
    end
    flush = 1'b1;
    step("stall_flush");
    flush = 1'b0;
    rand_inputs(); stall = 1'b0; pred = 2'b00;
    step("post_flush_load");
    stall = 1'b1; rst = 1'b1;
    step("reset_in_stall");
    rst = 1'b0; stall = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 31) == 0);
      step($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_array_id.md
# pe_array_id

Instruction Decode (ID) stage of the PE array; sits directly downstream of the PE IF stage and upstream of EX. It takes the IF-registered instruction, RF read-port addresses and bypass flags, and selects operand A/B from RF data, bypass sources or the sign-extended immediate. It decodes opcode, destination and memory controls, and resolves predication against the PE's local flag. It registers everything into the ID/EX pipeline register under stall/flush control.

## Interface
- DATA_WIDTH, 32, datapath width (`DEF_PE_DATA_WIDTH`)
- INS_WIDTH, 24, instruction width (`DEF_PE_INS_WIDTH`)
- RF_INDEX_WIDTH, 5, register index width (`DEF_RF_INDEX_WIDTH`)
- Clocking: one clock `iClk`; reset `iReset` is synchronous and active-high.
- iClk  in  1  system clock, posedge
- iReset  in  1  synchronous reset, active high
- iStall  in  1  hold ID/EX register contents
- iFlush  in  1  load bubble (NOP) into ID/EX
- iIF_ID_Instruction  in  INS_WIDTH  instruction from IF
- iPredication  in  2  predication mode from IF
- iIF_BP_Select_Imm  in  1  operand B is immediate
- iIF_BP_Bypass_Read_A / _B  in  1  port A/B takes bypass source
- iIF_BP_Bypass_Sel_A / _B  in  2  bypass source select
- iIF_BP_Data_Selection  in  3  data selection bits
- iRF_Read_Data_A / _B  in  DATA_WIDTH  RF read data
- iBP_EX_Result, iBP_WB_Result, iBP_Left_Data, iBP_Right_Data  in  DATA_WIDTH  bypass sources, sel 00/01/10/11
- iPE_Flag  in  1  local compare flag
- oID_EX_Operand_A / _B  out  DATA_WIDTH  EX operands
- oID_EX_Store_Data  out  DATA_WIDTH  resolved port-B data for SW
- oID_EX_Opcode  out  `DEF_INS_OPCODE_WIDTH`  opcode
- oID_EX_Dest_Index  out  RF_INDEX_WIDTH  destination
- oID_EX_Write_Enable, oID_EX_Mem_Read, oID_EX_Mem_Write  out  1  controls
- oID_EX_Data_Selection  out  3  forwarded data selection
- oID_EX_Valid  out  1  instruction executes

## Operation
- Port X data (X = A, B): Bypass_Read_X=1 -> 4:1 mux of bypass sources by Bypass_Sel_X; else iRF_Read_Data_X.
- Operand B = Select_Imm ? sign-extend(imm field `DEF_INS_IMM_*`) to DATA_WIDTH : resolved port-B data. Store_Data = resolved port-B data always.
- Opcode and dest taken from `DEF_INS_OPCODE_*` / `DEF_INS_DEST_*` fields.
- Mem_Read = opcode==`DEF_OPC_LW`; Mem_Write = opcode==`DEF_OPC_SW`.
- Write_Enable = not SW, not NOP, and dest < 28. Indices 28-31 are bypass-only, never written.
- Predication: 00 execute; 01 execute iff iPE_Flag=1; 10 execute iff iPE_Flag=0; 11 never.
- Not executing -> Valid, Write_Enable, Mem_Read, Mem_Write registered as 0. Operands, opcode, dest, data selection are still registered.
- Priority each edge: iReset > iFlush > iStall > normal load.
  - Flush: all outputs 0, opcode = `DEF_OPC_NOP`.
  - Stall: all ID/EX registers hold.

## Timing
- Reset: every output 0; opcode = `DEF_OPC_NOP`, which is 0.
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Operand muxing and predication evaluation are combinational before the register. iPE_Flag is sampled in the same cycle as the instruction.
- Stall and flush in the same cycle -> flush wins.
- Stall for k cycles: outputs constant for k cycles. Inputs presented during the stall are dropped; IF holds its outputs while stalled.
- Reset asserted mid-stall: registers clear on that edge; stall is ignored.
- Sign extension: imm MSB replicated into bits DATA_WIDTH-1 .. imm width.

## Structure
- Field bit positions, opcode constants (`DEF_OPC_LW`, `DEF_OPC_SW`, `DEF_OPC_NOP`), bypass select encodings, predication encodings and the bypass threshold 28 belong in shared `def-pe.v`.
- One sub-module, `pe_operand_sel`: a combinational 4:1 bypass mux plus RF/bypass select. Instantiated twice, for ports A and B.
- Pipeline registers, decode and predication logic live in `pe_array_id`.

## Test plan
- Reset: assert iReset with nonzero inputs -> all outputs 0 the cycle after the edge.
- Bypass: Bypass_Read_A=1, Sel_A=2'b10, iBP_Left_Data=32'h1234_5678, RF A=32'hFFFF_FFFF -> Operand_A=32'h1234_5678 after 1 cycle. Repeat for each Sel value on A and B.
- Immediate: I-type, imm=12'hF80, Select_Imm=1 -> Operand_B=32'hFFFF_FF80; Store_Data equals resolved port-B data.
- Predication: LW with pred=01, iPE_Flag=0 -> Valid=0, Mem_Read=0. Pred=10, flag=0 -> Valid=1, Mem_Read=1. Pred=11 -> Valid=0.
- Dest guard: ADD with dest=29 -> Write_Enable=0, Valid=1. Dest=5 -> Write_Enable=1.
- Stall/flush: stall 3 cycles while the input changes -> outputs frozen. Stall+flush together -> NOP bubble. Reset during stall -> cleared.
